// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
//   Shared helpers for param_fir_filter and its adder tree:
//     tree_depth  - number of pairwise adder stages for n inputs (0 for n <= 1)
//     acc_width   - full-precision accumulator width dw + cw + tree_depth(n)
//     saturate    - clamp a wide signed value into an ow-bit signed range
//     is_clamped  - 1 when saturate() would change the value
//   Wide values travel as SAT_W-bit signed vectors so one function serves
//   every parameterisation.
// -----------------------------------------------------------------------------
package fir_pkg;

    localparam int SAT_W = 128;

    function automatic int tree_depth(input int n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    function automatic int acc_width(input int dw, input int cw, input int n);
        return dw + cw + tree_depth(n);
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_hi(input int ow);
        return $signed((128'd1 << (ow - 1)) - 128'd1);
    endfunction

    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] v,
        input int                      ow
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = sat_hi(ow);
        lo = -hi - 128'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

    function automatic logic is_clamped(
        input logic signed [SAT_W-1:0] v,
        input int                      ow
    );
        logic signed [SAT_W-1:0] hi;
        hi = sat_hi(ow);
        return (v > hi) || (v < (-hi - 128'sd1));
    endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// -----------------------------------------------------------------------------
// fir_adder_tree
//   Pipelined pairwise sum of N signed W-bit inputs. The tree is laid out as a
//   complete binary heap of NP = 2^L leaves; leaves beyond N are zero. Every
//   internal node is a register, so all paths are exactly L stages long.
//   Ports:
//     clk      in   clock
//     reset_n  in   synchronous active-low reset (clears sums and valid pipe)
//     i_valid  in   input vector valid
//     i_data   in   N*W packed inputs, element k at [k*W +: W]
//     o_valid  out  i_valid delayed by L clocks
//     o_sum    out  signed sum, W+L bits (cannot overflow)
// -----------------------------------------------------------------------------
module fir_adder_tree
    import fir_pkg::*;
#(
    parameter int N = 21,
    parameter int W = 43
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             i_valid,
    input  logic [N*W-1:0]                   i_data,
    output logic                             o_valid,
    output logic signed [W+tree_depth(N)-1:0] o_sum
);

    localparam int L  = tree_depth(N);
    localparam int SW = W + L;
    localparam int NP = 1 << L;

    logic signed [SW-1:0] w_leaf [NP];

    for (genvar gl = 0; gl < NP; gl++) begin : g_leaf
        if (gl < N) begin : g_real
            assign w_leaf[gl] = SW'($signed(i_data[gl*W +: W]));
        end else begin : g_pad
            assign w_leaf[gl] = {SW{1'b0}};
        end
    end

    if (L == 0) begin : g_single
        assign o_sum   = w_leaf[0];
        assign o_valid = i_valid;
    end else begin : g_tree
        // Node i sums children 2i+1 and 2i+2; indices >= NP-1 are leaves.
        logic signed [SW-1:0] r_node [NP-1];
        logic signed [SW-1:0] w_lhs  [NP-1];
        logic signed [SW-1:0] w_rhs  [NP-1];
        logic [L-1:0]         r_vld;

        for (genvar gi = 0; gi < NP - 1; gi++) begin : g_node
            if (2 * gi + 1 >= NP - 1) begin : g_from_leaf
                assign w_lhs[gi] = w_leaf[2*gi+1-(NP-1)];
                assign w_rhs[gi] = w_leaf[2*gi+2-(NP-1)];
            end else begin : g_from_node
                assign w_lhs[gi] = r_node[2*gi+1];
                assign w_rhs[gi] = r_node[2*gi+2];
            end
        end

        // Register every internal node sum and shift the valid pipe.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                for (int i = 0; i < NP - 1; i++) begin
                    r_node[i] <= {SW{1'b0}};
                end
                r_vld <= {L{1'b0}};
            end else begin
                for (int i = 0; i < NP - 1; i++) begin
                    r_node[i] <= w_lhs[i] + w_rhs[i];
                end
                r_vld[0] <= i_valid;
                for (int i = 1; i < L; i++) begin
                    r_vld[i] <= r_vld[i-1];
                end
            end
        end

        assign o_sum   = r_node[0];
        assign o_valid = r_vld[L-1];
    end

endmodule

// File: rtl/param_fir_filter.sv
// -----------------------------------------------------------------------------
// param_fir_filter
//   Direct-form FIR with generic tap count: valid-gated delay line,
//   double-buffered coefficients (shadow shift chain + atomic commit),
//   registered full-precision products, pipelined adder tree, and a final
//   shift/saturate register. Latency 3 + clog2(NTAPS) clocks, 1 sample/clk.
//   Ports:
//     clk          in   sole clock
//     reset_n      in   synchronous active-low reset
//     cfg_din      in   coefficient word pushed into the shadow chain
//     cfg_we       in   push cfg_din (sh[0] <= cfg_din, sh[k] <= sh[k-1])
//     cfg_commit   in   copy shadow bank into active bank
//     cfg_pending  out  shadow written since last commit
//     len          out  constant NTAPS
//     in           in   signed input sample
//     valid_in     in   sample strobe
//     out          out  signed scaled saturated output (held between strobes)
//     valid_out    out  one-clock strobe per accepted sample
//     sat_cnt      out  saturation event counter
//   Build option: define FIR_SAT_CNT_EN to build the saturation counter;
//   otherwise sat_cnt is tied to zero.
// -----------------------------------------------------------------------------
module param_fir_filter
    import fir_pkg::*;
#(
    parameter int NTAPS     = 21,
    parameter int DW        = 18,
    parameter int CW        = 25,
    parameter int OW        = 18,
    parameter int OUT_SHIFT = 19
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [CW-1:0]        cfg_din,
    input  logic                 cfg_we,
    input  logic                 cfg_commit,
    output logic                 cfg_pending,
    output logic [31:0]          len,
    input  logic signed [DW-1:0] in,
    input  logic                 valid_in,
    output logic signed [OW-1:0] out,
    output logic                 valid_out,
    output logic [15:0]          sat_cnt
);

    localparam int PW = DW + CW;
    localparam int AW = acc_width(DW, CW, NTAPS);

    // Reset tap 0 to 1<<OUT_SHIFT so an unconfigured filter passes samples.
    localparam logic [63:0]   UNITY64    = 64'd1 << OUT_SHIFT;
    localparam logic [CW-1:0] COEF_UNITY = UNITY64[CW-1:0];

    logic signed [DW-1:0] r_x     [NTAPS];
    logic                 r_v_dl;
    logic signed [CW-1:0] r_coef  [NTAPS];
    logic        [CW-1:0] r_sh    [NTAPS];
    logic                 r_pending;
    logic signed [PW-1:0] r_prod  [NTAPS];
    logic                 r_v_prod;
    logic signed [OW-1:0] r_out;
    logic                 r_vout;

    logic [NTAPS*PW-1:0]  w_prod_flat;
    logic signed [AW-1:0] w_tree_sum;
    logic                 w_tree_valid;
    logic signed [AW-1:0] w_scaled;

    // Delay line: advances only on an accepted sample, holds on idle clocks.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < NTAPS; k++) begin
                r_x[k] <= {DW{1'b0}};
            end
            r_v_dl <= 1'b0;
        end else begin
            r_v_dl <= valid_in;
            if (valid_in) begin
                r_x[0] <= in;
                for (int k = 1; k < NTAPS; k++) begin
                    r_x[k] <= r_x[k-1];
                end
            end
        end
    end

    // Coefficient banks: commit copies the pre-shift shadow; a write in the
    // same clock re-arms cfg_pending for the freshly shifted word.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < NTAPS; k++) begin
                r_sh[k]   <= {CW{1'b0}};
                r_coef[k] <= {CW{1'b0}};
            end
            r_coef[0] <= COEF_UNITY;
            r_pending <= 1'b0;
        end else begin
            if (cfg_commit) begin
                for (int k = 0; k < NTAPS; k++) begin
                    r_coef[k] <= r_sh[k];
                end
            end
            if (cfg_we) begin
                r_sh[0] <= cfg_din;
                for (int k = 1; k < NTAPS; k++) begin
                    r_sh[k] <= r_sh[k-1];
                end
                r_pending <= 1'b1;
            end else if (cfg_commit) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Full-precision product register, loaded only for a fresh delay line.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < NTAPS; k++) begin
                r_prod[k] <= {PW{1'b0}};
            end
            r_v_prod <= 1'b0;
        end else begin
            r_v_prod <= r_v_dl;
            if (r_v_dl) begin
                for (int k = 0; k < NTAPS; k++) begin
                    r_prod[k] <= PW'(r_x[k]) * PW'(r_coef[k]);
                end
            end
        end
    end

    // Pack the products for the adder tree.
    always_comb begin
        w_prod_flat = {(NTAPS*PW){1'b0}};
        for (int k = 0; k < NTAPS; k++) begin
            w_prod_flat[k*PW +: PW] = r_prod[k];
        end
    end

    fir_adder_tree #(
        .N (NTAPS),
        .W (PW)
    ) u_tree (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (r_v_prod),
        .i_data  (w_prod_flat),
        .o_valid (w_tree_valid),
        .o_sum   (w_tree_sum)
    );

    // Floor scaling: arithmetic shift of the signed accumulator.
    assign w_scaled = w_tree_sum >>> OUT_SHIFT;

    // Output register: saturate on each valid sum, hold value otherwise.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out  <= {OW{1'b0}};
            r_vout <= 1'b0;
        end else begin
            r_vout <= w_tree_valid;
            if (w_tree_valid) begin
                r_out <= OW'(saturate(SAT_W'(w_scaled), OW));
            end
        end
    end

`ifdef FIR_SAT_CNT_EN
    logic [15:0] r_sat_cnt;

    // Count clamped valid outputs, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sat_cnt <= 16'd0;
        end else if (w_tree_valid && is_clamped(SAT_W'(w_scaled), OW)
                     && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign sat_cnt = r_sat_cnt;
`else
    assign sat_cnt = 16'd0;
`endif

    assign out         = r_out;
    assign valid_out   = r_vout;
    assign cfg_pending = r_pending;
    assign len         = 32'(NTAPS);

endmodule
